snoop_buf_sched: RTL and testbench

SNOOP_BUF_SCHED -- requirements
Module: snoop_buf_sched

---
 rtl/snoop_buf_sched.sv | 169 ++++++++++++++++
 tb/tb_snoop_buf_sched.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/snoop_buf_sched.sv
// Three-buffer ownership scheduler between a packet snooper, a filter CPU and a forwarder.
// Each buffer walks FREE->SNOOP->WAIT_F->FILT->(WAIT_O->OUT->)FREE; hand-offs use in-order index queues.
module snoop_buf_sched #(
    parameter int unsigned CNT_WIDTH = 16,
    parameter int unsigned NBUF      = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sn_done,
    output logic                 sn_rdy,
    output logic [1:0]           sn_sel,
    input  logic                 cpu_acc,
    input  logic                 cpu_rej,
    output logic                 cpu_rdy,
    output logic [1:0]           cpu_sel,
    input  logic                 fwd_done,
    output logic                 fwd_rdy,
    output logic [1:0]           fwd_sel,
    output logic [CNT_WIDTH-1:0] acc_cnt,
    output logic [CNT_WIDTH-1:0] rej_cnt
);

    localparam int unsigned SEL_W = 2;
    localparam int unsigned QCW   = 2;

    typedef enum logic [2:0] {
        B_FREE, B_SNOOP, B_WAIT_F, B_FILT, B_WAIT_O, B_OUT
    } buf_state_e;

    buf_state_e           st_q   [NBUF];
    buf_state_e           st_d   [NBUF];
    logic [SEL_W-1:0]     fq_q   [NBUF];
    logic [SEL_W-1:0]     fq_d   [NBUF];
    logic [SEL_W-1:0]     oq_q   [NBUF];
    logic [SEL_W-1:0]     oq_d   [NBUF];
    logic [QCW-1:0]       fq_cnt_q, fq_cnt_d, oq_cnt_q, oq_cnt_d;
    logic                 sn_rdy_d, cpu_rdy_d, fwd_rdy_d;
    logic [SEL_W-1:0]     sn_sel_d, cpu_sel_d, fwd_sel_d;
    logic [CNT_WIDTH-1:0] acc_cnt_d, rej_cnt_d;
    logic                 f_push, f_pop, o_push, o_pop, found;
    logic [SEL_W-1:0]     f_push_idx, o_push_idx;

    // State register: every output is a flop, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NBUF; i++) begin
                st_q[i] <= B_FREE;
                fq_q[i] <= '0;
                oq_q[i] <= '0;
            end
            fq_cnt_q <= '0;
            oq_cnt_q <= '0;
            sn_rdy   <= 1'b0;
            cpu_rdy  <= 1'b0;
            fwd_rdy  <= 1'b0;
            sn_sel   <= '0;
            cpu_sel  <= '0;
            fwd_sel  <= '0;
            acc_cnt  <= '0;
            rej_cnt  <= '0;
        end else begin
            st_q     <= st_d;
            fq_q     <= fq_d;
            oq_q     <= oq_d;
            fq_cnt_q <= fq_cnt_d;
            oq_cnt_q <= oq_cnt_d;
            sn_rdy   <= sn_rdy_d;
            cpu_rdy  <= cpu_rdy_d;
            fwd_rdy  <= fwd_rdy_d;
            sn_sel   <= sn_sel_d;
            cpu_sel  <= cpu_sel_d;
            fwd_sel  <= fwd_sel_d;
            acc_cnt  <= acc_cnt_d;
            rej_cnt  <= rej_cnt_d;
        end
    end

    always_comb begin
        st_d       = st_q;
        fq_d       = fq_q;
        oq_d       = oq_q;
        fq_cnt_d   = fq_cnt_q;
        oq_cnt_d   = oq_cnt_q;
        sn_rdy_d   = sn_rdy;
        cpu_rdy_d  = cpu_rdy;
        fwd_rdy_d  = fwd_rdy;
        sn_sel_d   = sn_sel;
        cpu_sel_d  = cpu_sel;
        fwd_sel_d  = fwd_sel;
        acc_cnt_d  = acc_cnt;
        rej_cnt_d  = rej_cnt;
        f_push     = 1'b0;
        f_pop      = 1'b0;
        o_push     = 1'b0;
        o_pop      = 1'b0;
        found      = 1'b0;
        f_push_idx = '0;
        o_push_idx = '0;

        // Completions; accept wins when both filter verdicts arrive together
        if (sn_rdy && sn_done) begin
            st_d[sn_sel] = B_WAIT_F;
            sn_rdy_d     = 1'b0;
            f_push       = 1'b1;
            f_push_idx   = sn_sel;
        end
        if (cpu_rdy && (cpu_acc || cpu_rej)) begin
            cpu_rdy_d = 1'b0;
            if (cpu_acc) begin
                st_d[cpu_sel] = B_WAIT_O;
                o_push        = 1'b1;
                o_push_idx    = cpu_sel;
                acc_cnt_d     = acc_cnt + CNT_WIDTH'(1);
            end else begin
                st_d[cpu_sel] = B_FREE;
                rej_cnt_d     = rej_cnt + CNT_WIDTH'(1);
            end
        end
        if (fwd_rdy && fwd_done) begin
            st_d[fwd_sel] = B_FREE;
            fwd_rdy_d     = 1'b0;
        end

        // Grants look only at registered state, so a buffer freed this cycle waits one cycle
        if (!sn_rdy) begin
            for (int unsigned i = 0; i < NBUF; i++) begin
                if (!found && st_q[i] == B_FREE) begin
                    found    = 1'b1;
                    st_d[i]  = B_SNOOP;
                    sn_rdy_d = 1'b1;
                    sn_sel_d = SEL_W'(i);
                end
            end
        end
        if (!cpu_rdy && fq_cnt_q != '0) begin
            st_d[fq_q[0]] = B_FILT;
            cpu_rdy_d     = 1'b1;
            cpu_sel_d     = fq_q[0];
            f_pop         = 1'b1;
        end
        if (!fwd_rdy && oq_cnt_q != '0) begin
            st_d[oq_q[0]] = B_OUT;
            fwd_rdy_d     = 1'b1;
            fwd_sel_d     = oq_q[0];
            o_pop         = 1'b1;
        end

        // Queue maintenance: pop shifts toward the head, push appends after the survivors
        if (f_pop) begin
            for (int unsigned i = 0; i < NBUF - 1; i++) fq_d[i] = fq_q[i+1];
            fq_d[NBUF-1] = '0;
            fq_cnt_d     = fq_cnt_q - QCW'(1);
        end
        if (f_push) begin
            fq_d[fq_cnt_d] = f_push_idx;
            fq_cnt_d       = fq_cnt_d + QCW'(1);
        end
        if (o_pop) begin
            for (int unsigned i = 0; i < NBUF - 1; i++) oq_d[i] = oq_q[i+1];
            oq_d[NBUF-1] = '0;
            oq_cnt_d     = oq_cnt_q - QCW'(1);
        end
        if (o_push) begin
            oq_d[oq_cnt_d] = o_push_idx;
            oq_cnt_d       = oq_cnt_d + QCW'(1);
        end
    end

endmodule

// File: tb/tb_snoop_buf_sched.sv
// Scenario bench for snoop_buf_sched: expected filter/forwarder buffer order kept in scoreboard queues.
module tb_snoop_buf_sched;

    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sn_done, cpu_acc, cpu_rej, fwd_done;
    logic          sn_rdy, cpu_rdy, fwd_rdy;
    logic [1:0]    sn_sel, cpu_sel, fwd_sel;
    logic [CW-1:0] acc_cnt, rej_cnt;

    int total = 0;
    int bad   = 0;
    int fexp[$];
    int oexp[$];
    int acc_exp = 0;
    int rej_exp = 0;
    int e;

    snoop_buf_sched #(.CNT_WIDTH(CW), .NBUF(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .sn_done(sn_done), .sn_rdy(sn_rdy), .sn_sel(sn_sel),
        .cpu_acc(cpu_acc), .cpu_rej(cpu_rej), .cpu_rdy(cpu_rdy), .cpu_sel(cpu_sel),
        .fwd_done(fwd_done), .fwd_rdy(fwd_rdy), .fwd_sel(fwd_sel),
        .acc_cnt(acc_cnt), .rej_cnt(rej_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        sn_done = 0; cpu_acc = 0; cpu_rej = 0; fwd_done = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        fexp.delete(); oexp.delete();
        acc_exp = 0; rej_exp = 0;
        tick(); tick();
        rst_n = 1;
        tick();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1;
        #2 rst_n = 0;
        #1;
        total++; if ({sn_rdy, cpu_rdy, fwd_rdy} !== 3'b000) begin bad++; $display("FAIL reset_rdy got=%b exp=000", {sn_rdy, cpu_rdy, fwd_rdy}); end
        total++; if ({sn_sel, cpu_sel, fwd_sel} !== 6'd0) begin bad++; $display("FAIL reset_sel got=%b exp=0", {sn_sel, cpu_sel, fwd_sel}); end
        total++; if (acc_cnt !== 0 || rej_cnt !== 0) begin bad++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", acc_cnt, rej_cnt); end
        tick(); tick();
        rst_n = 1;
    endtask

    task automatic test_idle();
        tick();
        total++; if (sn_rdy !== 1'b1 || sn_sel !== 2'd0) begin bad++; $display("FAIL idle_grant got=%b/%0d exp=1/0", sn_rdy, sn_sel); end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (cpu_rdy !== 1'b0 || fwd_rdy !== 1'b0 || sn_sel !== 2'd0) begin bad++; $display("FAIL idle_quiet cycle=%0d got=%b%b sel=%0d exp=00 sel=0", i, cpu_rdy, fwd_rdy, sn_sel); end
        end
    endtask

    task automatic test_pipeline();
        sn_done = 1; fexp.push_back(0);
        tick(); sn_done = 0;
        total++; if (sn_rdy !== 1'b0 || cpu_rdy !== 1'b0) begin bad++; $display("FAIL pipe_gap got=%b%b exp=00", sn_rdy, cpu_rdy); end
        tick();
        total++; e = fexp.pop_front();
        if (cpu_rdy !== 1'b1 || cpu_sel !== 2'(e)) begin bad++; $display("FAIL pipe_cpu got=%b/%0d exp=1/%0d", cpu_rdy, cpu_sel, e); end
        total++; if (sn_rdy !== 1'b1 || sn_sel !== 2'd1) begin bad++; $display("FAIL pipe_sn got=%b/%0d exp=1/1", sn_rdy, sn_sel); end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            total++; if (sn_rdy !== 1'b1 || sn_sel !== 2'(i)) begin bad++; $display("FAIL fill_grant%0d got=%b/%0d exp=1/%0d", i, sn_rdy, sn_sel, i); end
            sn_done = 1; fexp.push_back(i);
            tick(); sn_done = 0;
            tick();
            if (i == 0) begin
                total++; e = fexp.pop_front();
                if (cpu_rdy !== 1'b1 || cpu_sel !== 2'(e)) begin bad++; $display("FAIL fill_cpu got=%b/%0d exp=1/%0d", cpu_rdy, cpu_sel, e); end
            end
        end
        tick(); tick();
        total++; if (sn_rdy !== 1'b0 || fwd_rdy !== 1'b0) begin bad++; $display("FAIL fill_full got=%b%b exp=00", sn_rdy, fwd_rdy); end
        cpu_acc = 1; oexp.push_back(0); acc_exp++;
        tick(); cpu_acc = 0;
        total++; if (acc_cnt !== CW'(acc_exp) || cpu_rdy !== 1'b0) begin bad++; $display("FAIL fill_acc got=%0d/%b exp=%0d/0", acc_cnt, cpu_rdy, acc_exp); end
        tick();
        total++; e = fexp.pop_front();
        if (cpu_rdy !== 1'b1 || cpu_sel !== 2'(e)) begin bad++; $display("FAIL fill_cpu2 got=%b/%0d exp=1/%0d", cpu_rdy, cpu_sel, e); end
        total++; e = oexp.pop_front();
        if (fwd_rdy !== 1'b1 || fwd_sel !== 2'(e)) begin bad++; $display("FAIL fill_fwd got=%b/%0d exp=1/%0d", fwd_rdy, fwd_sel, e); end
        fwd_done = 1;
        tick(); fwd_done = 0;
        total++; if (sn_rdy !== 1'b0 || fwd_rdy !== 1'b0) begin bad++; $display("FAIL fill_nofast got=%b%b exp=00", sn_rdy, fwd_rdy); end
        tick();
        total++; if (sn_rdy !== 1'b1 || sn_sel !== 2'd0) begin bad++; $display("FAIL fill_regrant got=%b/%0d exp=1/0", sn_rdy, sn_sel); end
    endtask

    task automatic test_acc_rej_both();
        cpu_acc = 1; cpu_rej = 1; oexp.push_back(1); acc_exp++;
        tick(); cpu_acc = 0; cpu_rej = 0;
        total++; if (acc_cnt !== CW'(acc_exp) || rej_cnt !== CW'(rej_exp)) begin bad++; $display("FAIL both_cnt got=%0d/%0d exp=%0d/%0d", acc_cnt, rej_cnt, acc_exp, rej_exp); end
        tick();
        total++; e = oexp.pop_front();
        if (fwd_rdy !== 1'b1 || fwd_sel !== 2'(e)) begin bad++; $display("FAIL both_fwd got=%b/%0d exp=1/%0d", fwd_rdy, fwd_sel, e); end
        total++; e = fexp.pop_front();
        if (cpu_rdy !== 1'b1 || cpu_sel !== 2'(e)) begin bad++; $display("FAIL both_cpu got=%b/%0d exp=1/%0d", cpu_rdy, cpu_sel, e); end
    endtask

    task automatic test_same_cycle();
        sn_done = 1; cpu_rej = 1; fwd_done = 1; fexp.push_back(0); rej_exp++;
        tick(); clear_inputs();
        total++; if ({sn_rdy, cpu_rdy, fwd_rdy} !== 3'b000) begin bad++; $display("FAIL same_rdy got=%b exp=000", {sn_rdy, cpu_rdy, fwd_rdy}); end
        total++; if (rej_cnt !== CW'(rej_exp) || acc_cnt !== CW'(acc_exp)) begin bad++; $display("FAIL same_cnt got=%0d/%0d exp=%0d/%0d", acc_cnt, rej_cnt, acc_exp, rej_exp); end
        tick();
        total++; if (sn_rdy !== 1'b1 || sn_sel !== 2'd1) begin bad++; $display("FAIL same_sn got=%b/%0d exp=1/1", sn_rdy, sn_sel); end
        total++; e = fexp.pop_front();
        if (cpu_rdy !== 1'b1 || cpu_sel !== 2'(e) || fwd_rdy !== 1'b0) begin bad++; $display("FAIL same_cpu got=%b/%0d fwd=%b exp=1/%0d fwd=0", cpu_rdy, cpu_sel, fwd_rdy, e); end
    endtask

    task automatic test_ignore();
        fwd_done = 1;
        tick(); fwd_done = 0;
        total++; if (fwd_rdy !== 1'b0 || sn_sel !== 2'd1 || cpu_sel !== 2'd0 || cpu_rdy !== 1'b1) begin bad++; $display("FAIL ignore got=%b/%0d/%0d/%b exp=0/1/0/1", fwd_rdy, sn_sel, cpu_sel, cpu_rdy); end
    endtask

    task automatic test_reset_busy();
        sn_done = 1; fexp.push_back(1);
        tick(); sn_done = 0;
        tick();
        total++; if (sn_rdy !== 1'b1 || sn_sel !== 2'd2) begin bad++; $display("FAIL busy_pre got=%b/%0d exp=1/2", sn_rdy, sn_sel); end
        #2 rst_n = 0;
        #1;
        fexp.delete(); oexp.delete(); acc_exp = 0; rej_exp = 0;
        total++; if ({sn_rdy, cpu_rdy, fwd_rdy} !== 3'b000 || acc_cnt !== CW'(acc_exp) || rej_cnt !== CW'(rej_exp)) begin bad++; $display("FAIL busy_rst got=%b cnt=%0d/%0d exp=000 0/0", {sn_rdy, cpu_rdy, fwd_rdy}, acc_cnt, rej_cnt); end
        tick();
        rst_n = 1;
        total++; if (sn_rdy !== 1'b0) begin bad++; $display("FAIL busy_hold got=%b exp=0", sn_rdy); end
        tick();
        total++; if (sn_rdy !== 1'b1 || sn_sel !== 2'd0 || cpu_rdy !== 1'b0) begin bad++; $display("FAIL busy_first got=%b/%0d cpu=%b exp=1/0 cpu=0", sn_rdy, sn_sel, cpu_rdy); end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_pipeline();
        test_fill();
        test_acc_rej_both();
        test_same_cycle();
        test_ignore();
        test_reset_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
